// File: rtl/tile_map_arbiter_if.sv
// Tile map bus: level ROM load port, two player RMW ports and the renderer read port.
// Latency and flow control are set by tile_map_arbiter: ack pulses one edge after req, vid_data lags vid_addr by one cycle.
// There is no backpressure beyond req/ack. Requesters hold their request until ack, and the renderer port is never stalled.
interface tile_map_arbiter_if;
  logic       load_start;
  logic [8:0] rom_addr;
  logic [1:0] rom_data;
  logic       busy;
  logic [1:0] req;
  logic [1:0] we;
  logic [8:0] addr0;
  logic [8:0] addr1;
  logic [1:0] wdata0;
  logic [1:0] wdata1;
  logic [1:0] ack;
  logic [1:0] rdata;
  logic [8:0] vid_addr;
  logic [1:0] vid_data;

  // Arbiter side.
  modport slave (
    input  load_start, rom_data, req, we, addr0, addr1, wdata0, wdata1, vid_addr,
    output rom_addr, busy, ack, rdata, vid_data
  );

  // Requester, ROM and renderer side.
  modport master (
    output load_start, rom_data, req, we, addr0, addr1, wdata0, wdata1, vid_addr,
    input  rom_addr, busy, ack, rdata, vid_data
  );
endinterface

// File: rtl/tile_map_arbiter.sv
// Shared 20x15 tile map: ROM load, then round-robin read-modify-write for two players plus a renderer read port.
// A player gets ack and rdata one edge after its request is seen in IDLE. The renderer sees vid_data one cycle after vid_addr.
// Requesters wait, holding req, through LOAD and SERVE. Grants alternate while both players request; the renderer never stalls.
module tile_map_arbiter #(
  parameter int         MAP_W    = 20,
  parameter int         MAP_H    = 15,
  parameter logic [1:0] OOB_CODE = 2'd1
) (
  input  logic           frame_clk,
  input  logic           Reset,
  tile_map_arbiter_if.slave bus
);
  localparam int         TILES    = MAP_W * MAP_H;
  localparam logic [8:0] TILES_9  = 9'(TILES);
  localparam logic [8:0] LAST_IDX = 9'(TILES - 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;

  logic [1:0] tile_mem [0:TILES-1];
  logic [1:0] state;
  logic [8:0] load_idx;
  logic       rr;
  logic       load_pending;

  logic       load_go;
  logic       gnt_vld;
  logic       g;
  logic [8:0] addr_g;
  logic [1:0] wdata_g;
  logic       we_g;
  logic       g_in_range;
  logic       vid_in_range;

  assign bus.rom_addr = load_idx;
  assign bus.busy     = (state == S_LOAD);

  // Grant selection: a lone requester wins outright, and rr breaks ties. A pending reload beats any request.
  always_comb begin
    load_go      = (state == S_IDLE) && (load_pending || bus.load_start);
    gnt_vld      = (state == S_IDLE) && !load_go && (bus.req != 2'b00);
    g            = (bus.req == 2'b11) ? rr : bus.req[1];
    addr_g       = g ? bus.addr1  : bus.addr0;
    wdata_g      = g ? bus.wdata1 : bus.wdata0;
    we_g         = bus.we[g];
    g_in_range   = (addr_g < TILES_9);
    vid_in_range = (bus.vid_addr < TILES_9);
  end

  // Tile storage is left alone by reset. It is written by the ROM load, or by an in-range player write at grant.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      if (state == S_LOAD)
        tile_mem[load_idx] <= bus.rom_data;
      else if (gnt_vld && we_g && g_in_range)
        tile_mem[addr_g] <= wdata_g;
    end
  end

  // Control FSM: walk the ROM, grant one request, then spend one cycle in SERVE to drop ack.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_LOAD;
      load_idx     <= '0;
      rr           <= 1'b0;
      load_pending <= 1'b0;
      bus.ack      <= 2'b00;
      bus.rdata    <= 2'b00;
    end else begin
      bus.ack <= 2'b00;
      case (state)
        S_LOAD: begin
          if (load_idx == LAST_IDX) begin
            load_idx <= '0;
            state    <= S_IDLE;
          end else begin
            load_idx <= load_idx + 9'd1;
          end
        end
        S_IDLE: begin
          if (load_go) begin
            load_pending <= 1'b0;
            state        <= S_LOAD;
          end else if (gnt_vld) begin
            bus.rdata <= g_in_range ? tile_mem[addr_g] : OOB_CODE;
            bus.ack   <= g ? 2'b10 : 2'b01;
            rr        <= ~g;
            state     <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (bus.load_start)
            load_pending <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Renderer read: one cycle latency, blanked to 0 during load, and out-of-range addresses read as wall.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      bus.vid_data <= 2'b00;
    else if (state == S_LOAD)
      bus.vid_data <= 2'b00;
    else
      bus.vid_data <= vid_in_range ? tile_mem[bus.vid_addr] : OOB_CODE;
  end
endmodule

// File: doc/tile_map_arbiter.md
# tile_map_arbiter

Owns the 20x15 tile map shared by both tank controllers and the renderer. Loads the map from the level ROM after reset or on request, then arbitrates the two player ports round-robin, one read-modify-write transaction per grant. Tanks use it for move and bullet collision queries and brick clearing. The renderer has its own read-only port that does not arbitrate.

## Interface
- MAP_W, 20, tiles per row
- MAP_H, 15, tile rows; TILES = MAP_W*MAP_H = 300
- OOB_CODE, 2'd1, value returned for any address >= TILES (reads as wall)

Ports:
- frame_clk  in  1  clock
- Reset  in  1  reset, asynchronous, active-high
- load_start  in  1  single-cycle pulse; reload the map from ROM
- rom_addr  out  9  level ROM address
- rom_data  in  2  level ROM data, combinational from rom_addr
- busy  out  1  high while loading
- req  in  2  per-player request; req[0] is player 1, req[1] is player 2
- we  in  2  per-player write enable, qualified by req
- addr0, addr1  in  9  tile index, y*MAP_W+x
- wdata0, wdata1  in  2  write value (0 empty, 1 wall, 2 brick, 3 reserved)
- ack  out  2  one-cycle grant-complete pulse
- rdata  out  2  tile value before the write; valid in the ack cycle
- vid_addr  in  9  renderer tile index
- vid_data  out  2  renderer tile value, 1-cycle latency

## Operation
- Storage is 300 x 2 bits. It is not cleared by reset; it is filled by LOAD.
- States: LOAD, IDLE, SERVE.
- Reset values: state=LOAD, load_idx=0, rr=0, ack=0, rdata=0, vid_data=0, busy=1, rom_addr=0, load_pending=0.

LOAD:
- rom_addr = load_idx. Each edge writes tile[load_idx] = rom_data, then load_idx++.
- After writing index 299: go to IDLE, busy=0, load_idx=0.
- Load takes exactly 300 cycles. req is ignored (no ack). load_start is ignored.

IDLE:
- If load_pending or load_start: go to LOAD, busy=1, clear load_pending. This takes precedence over req.
- Otherwise, if req is nonzero, pick the grant g:
  - one request pending: g = that requester.
  - both pending: g = rr.
- Then, on the same edge:
  - rdata <= tile[addr_g], or OOB_CODE if addr_g >= 300.
  - if we[g] and addr_g < 300: tile[addr_g] <= wdata_g. Out-of-range writes are dropped.
  - rr <= ~g, ack[g] <= 1, go to SERVE.

SERVE:
- ack returns to 0 and state goes to IDLE. Nothing is granted in this state.
- A load_start seen in SERVE sets load_pending.

Requester rules:
- Hold req, we, addr and wdata stable until ack.
- Drop req on the edge after ack is seen. A req still high in the next IDLE cycle is a new transaction.

Renderer port:
- vid_data <= busy ? 0 : (vid_addr < 300 ? tile[vid_addr] : OOB_CODE), every edge.

rdata holds its value until the next grant.

## Timing
- Grant decided at edge E (state IDLE); ack high during cycle E..E+1; rdata valid from E.
- Throughput is at most one transaction per 2 cycles. With both players streaming, grants alternate P1, P2, P1…
- Write commits at E. A renderer or arbiter read sampled at E returns the old value; sampled at E+1 or later returns the new value.
- Worst-case wait for a request arriving while the other player is served: 2 cycles.
- Reset mid-transaction or mid-load: immediate return to LOAD state.
  - ack drops asynchronously.
  - Tiles already written keep their values until overwritten by the reload.
- load_start and req in the same IDLE cycle: load wins. The request is served after the load, provided req is still held.

## Test plan
- Release reset with the ROM patterned tile[i] = i%3 → busy=1 for exactly 300 cycles, no ack; afterwards vid_addr=5 returns 2 and vid_addr=299 returns 2.
- Single read: req=01, addr0=21 (wall) → ack=01 one cycle later for one cycle; rdata=1; the map is unchanged.
- Simultaneous: req=11 held with re-requests → acks 01, 10, 01, 10 on every other cycle starting from rr=0.
- Brick clear:
  - req[1], we[1], addr1=45 (brick), wdata1=0 → rdata=2.
  - A following read of 45 returns 0.
  - vid_data for 45 reads 0 from the cycle after the grant edge.
- Out of range: addr0=300, we=1 → rdata=1 (OOB_CODE) and no storage change. vid_addr=511 → vid_data=1.
- Load interaction:
  - load_start during SERVE → load starts on the next IDLE; a req pending at the time receives no ack until 300 cycles later.
  - Reset asserted at load_idx=150 → load restarts from 0.
